// File: rtl/noc_buffer_out.sv
// noc_buffer_out: store-and-forward transmit packetizer.
// Prepends a routing header to each buffered packet and emits it on the NoC.
`timescale 1ns/1ps
module noc_buffer_out #(
  parameter int XY_SZ       = 4,
  parameter int FIFO_ADDR_W = 8,
  parameter int DESC_ADDR_W = 2
) (
  input  logic               clk_line,
  input  logic               clk_line_rst_high,
  input  logic [2*XY_SZ-1:0] HsrcId,
  input  logic [XY_SZ-1:0]   in_dest_x,
  input  logic [XY_SZ-1:0]   in_dest_y,
  input  logic               stream_in_TVALID_int,
  input  logic [31:0]        stream_in_TDATA_int,
  input  logic [3:0]         stream_in_TKEEP_int,
  input  logic               stream_in_TLAST_int,
  output logic               stream_in_TREADY_int,
  input  logic               stream_out_TREADY,
  output logic               stream_out_TVALID,
  output logic [31:0]        stream_out_TDATA,
  output logic [3:0]         stream_out_TKEEP,
  output logic               stream_out_TLAST
);

  localparam int DEPTH   = 1 << FIFO_ADDR_W;
  localparam int DDEPTH  = 1 << DESC_ADDR_W;
  localparam int MAX_LEN = (DEPTH > 255) ? 255 : DEPTH;
  localparam int DW      = 2*XY_SZ + 8;
  localparam logic [7:0] LAST_CNT = 8'(MAX_LEN - 1);

  typedef enum logic [1:0] {
    IDLE,
    HEADER,
    PAYLOAD
  } state_t;

  logic [36:0]            pmem_q [DEPTH];
  logic [FIFO_ADDR_W:0]   pwr_q, prd_q;
  logic [DW-1:0]          dmem_q [DDEPTH];
  logic [DESC_ADDR_W:0]   dwr_q, drd_q;
  logic [7:0]             cnt_q;
  logic [XY_SZ-1:0]       dx_q, dy_q;
  logic [DW-1:0]          hdr_q;
  state_t                 state_q;

  logic                   pf_full, df_full, df_empty;
  logic                   win, last_w;
  logic [XY_SZ-1:0]       dx_cur, dy_cur;
  logic [36:0]            head;
  logic [31:0]            hdr_word;

  assign pf_full  = (pwr_q[FIFO_ADDR_W] != prd_q[FIFO_ADDR_W]) &&
                    (pwr_q[FIFO_ADDR_W-1:0] == prd_q[FIFO_ADDR_W-1:0]);
  assign df_full  = (dwr_q[DESC_ADDR_W] != drd_q[DESC_ADDR_W]) &&
                    (dwr_q[DESC_ADDR_W-1:0] == drd_q[DESC_ADDR_W-1:0]);
  assign df_empty = (dwr_q == drd_q);

  assign stream_in_TREADY_int = !clk_line_rst_high && !pf_full && !df_full;
  assign win    = stream_in_TVALID_int && stream_in_TREADY_int;
  assign last_w = stream_in_TLAST_int || (cnt_q == LAST_CNT);
  // First beat of a packet uses the live destination, later beats the latch.
  assign dx_cur = (cnt_q == 8'd0) ? in_dest_x : dx_q;
  assign dy_cur = (cnt_q == 8'd0) ? in_dest_y : dy_q;

  assign head = pmem_q[prd_q[FIFO_ADDR_W-1:0]];

  assign hdr_word = {4'(hdr_q[8+XY_SZ +: XY_SZ]),
                     4'(hdr_q[8 +: XY_SZ]),
                     8'(HsrcId),
                     hdr_q[7:0],
                     8'h00};

  always_ff @(posedge clk_line) begin
    if (win) begin
      pmem_q[pwr_q[FIFO_ADDR_W-1:0]] <= {last_w, stream_in_TKEEP_int,
                                         stream_in_TDATA_int};
    end
    if (win && last_w) begin
      dmem_q[dwr_q[DESC_ADDR_W-1:0]] <= {dx_cur, dy_cur, cnt_q + 8'd1};
    end
  end

  always_ff @(posedge clk_line) begin
    if (clk_line_rst_high) begin
      pwr_q <= '0;
      dwr_q <= '0;
      cnt_q <= '0;
      dx_q  <= '0;
      dy_q  <= '0;
    end else if (win) begin
      pwr_q <= pwr_q + 1'b1;
      dx_q  <= dx_cur;
      dy_q  <= dy_cur;
      if (last_w) begin
        cnt_q <= '0;
        dwr_q <= dwr_q + 1'b1;
      end else begin
        cnt_q <= cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk_line) begin
    if (clk_line_rst_high) begin
      state_q <= IDLE;
      prd_q   <= '0;
      drd_q   <= '0;
      hdr_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: if (!df_empty) begin
          hdr_q   <= dmem_q[drd_q[DESC_ADDR_W-1:0]];
          drd_q   <= drd_q + 1'b1;
          state_q <= HEADER;
        end
        HEADER: if (stream_out_TREADY) state_q <= PAYLOAD;
        PAYLOAD: if (stream_out_TREADY) begin
          prd_q <= prd_q + 1'b1;
          if (head[36]) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    stream_out_TVALID = 1'b0;
    stream_out_TDATA  = '0;
    stream_out_TKEEP  = '0;
    stream_out_TLAST  = 1'b0;
    unique case (1'b1)
      (state_q == HEADER): begin
        stream_out_TVALID = 1'b1;
        stream_out_TDATA  = hdr_word;
        stream_out_TKEEP  = 4'hF;
      end
      (state_q == PAYLOAD): begin
        stream_out_TVALID = 1'b1;
        stream_out_TDATA  = head[31:0];
        stream_out_TKEEP  = head[35:32];
        stream_out_TLAST  = head[36];
      end
      default: ;
    endcase
  end

endmodule
